// File: rtl/aud_i2s_tx_fifo.sv
// aud_i2s_tx_fifo: stereo I2S / left-justified DAC transmitter fed from a sample-pair FIFO
module aud_i2s_tx_fifo #(
  parameter int DATA_W      = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int MODE        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_en,
  input  logic                          i_bclk,
  input  logic                          i_daclrck,
  input  logic                          i_valid,
  input  logic [DATA_W-1:0]             i_data_l,
  input  logic [DATA_W-1:0]             i_data_r,
  output logic                          o_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_underrun,
  output logic                          o_aud_dacdat
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_W);
  localparam logic LJ = (MODE != 0);
  typedef enum logic [1:0] {IDLE, ARM, LEFT, RIGHT} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] bclk_sync_q, bclk_sync_d, lrck_sync_q, lrck_sync_d;
  logic bclk_prev_q, bclk_prev_d, lrck_q, lrck_d;
  logic [LW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic ready_q, ready_d, underrun_q, underrun_d, dout_q, dout_d;
  logic [DATA_W-1:0] shreg_q, shreg_d, hold_r_q, hold_r_d, load;
  logic [CW-1:0] bitcnt_q, bitcnt_d;
  logic [DATA_W-1:0] mem_l [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic bclk_s, lrck_s, fall, slot_edge, left_edge, right_edge;
  logic playing, empty, push, pop_req, pop, load_r;
  assign o_ready      = ready_q & ~i_rst;
  assign o_level      = wr_ptr_q - rd_ptr_q;
  assign o_underrun   = underrun_q;
  assign o_aud_dacdat = dout_q;
  always_comb begin
    bclk_sync_d = {bclk_sync_q[SYNC_STAGES-2:0], i_bclk};
    lrck_sync_d = {lrck_sync_q[SYNC_STAGES-2:0], i_daclrck};
    bclk_s      = bclk_sync_q[SYNC_STAGES-1];
    lrck_s      = lrck_sync_q[SYNC_STAGES-1];
    bclk_prev_d = bclk_s;
    fall        = bclk_prev_q & ~bclk_s;
    lrck_d      = fall ? lrck_s : lrck_q;
    slot_edge   = fall & (lrck_s != lrck_q);
    left_edge   = slot_edge & ~lrck_s;
    right_edge  = slot_edge & lrck_s;
    playing     = i_en & (state_q == LEFT || state_q == RIGHT);
    empty       = wr_ptr_q == rd_ptr_q;
    push        = i_valid & o_ready;
    pop_req     = i_en & left_edge & (state_q != IDLE);
    pop         = pop_req & ~empty;
    load_r      = playing & right_edge & (state_q == LEFT);
    wr_ptr_d    = wr_ptr_q + LW'(push);
    rd_ptr_d    = rd_ptr_q + LW'(pop);
    ready_d     = (wr_ptr_d - rd_ptr_d) != FULL;
    underrun_d  = underrun_q | (pop_req & empty);
    hold_r_d    = pop_req ? (empty ? '0 : mem_r[rd_ptr_q[AW-1:0]]) : hold_r_q;
    load        = pop_req ? (empty ? '0 : mem_l[rd_ptr_q[AW-1:0]]) : hold_r_q;
    state_d     = !i_en ? IDLE : state_q == IDLE ? ARM : pop_req ? LEFT : load_r ? RIGHT : state_q;
    shreg_d     = shreg_q;
    bitcnt_d    = bitcnt_q;
    dout_d      = dout_q & playing;
    // Left-justified drives the MSB on the slot edge itself; I2S waits one fall
    if (pop_req | load_r) begin
      shreg_d  = LJ ? load << 1 : load;
      bitcnt_d = LJ ? CW'(1) : '0;
      dout_d   = LJ & load[DATA_W-1];
    end else if (playing & fall) begin
      dout_d   = (bitcnt_q < LAST) ? shreg_q[DATA_W-1] : 1'b0;
      shreg_d  = shreg_q << 1;
      bitcnt_d = (bitcnt_q < LAST) ? bitcnt_q + CW'(1) : bitcnt_q;
    end
  end
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_l[wr_ptr_q[AW-1:0]] <= i_data_l;
      mem_r[wr_ptr_q[AW-1:0]] <= i_data_r;
    end
    if (i_rst) begin
      state_q     <= IDLE;
      bclk_sync_q <= '0;
      lrck_sync_q <= '0;
      bclk_prev_q <= 1'b0;
      lrck_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ready_q     <= 1'b1;
      underrun_q  <= 1'b0;
      dout_q      <= 1'b0;
      shreg_q     <= '0;
      hold_r_q    <= '0;
      bitcnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      bclk_sync_q <= bclk_sync_d;
      lrck_sync_q <= lrck_sync_d;
      bclk_prev_q <= bclk_prev_d;
      lrck_q      <= lrck_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ready_q     <= ready_d;
      underrun_q  <= underrun_d;
      dout_q      <= dout_d;
      shreg_q     <= shreg_d;
      hold_r_q    <= hold_r_d;
      bitcnt_q    <= bitcnt_d;
    end
  end
endmodule
